pc_fetch_gen: RTL and testbench
===============================

PC_FETCH_GEN -- requirements
Module: pc_fetch_gen

Interface
REQ-001 Parameter ADDR_W, default 32, PC and fetch address width.
REQ-002 Parameter RESET_PC, default 0 (ADDR_W bits), PC after any reset.
REQ-003 Parameter STEP, default 4, sequential PC increment; SHALL be 2 or 4.
REQ-004 Parameter MAX_OUT, default 2, maximum in-flight fetches; SHALL be 1, 2, 4 or 8.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 jump_flag_i  in  1  execute-stage jump request.
REQ-008 jump_addr_i  in  ADDR_W  jump target.
REQ-009 hold_flag_i  in  1  execute-stage hold/refetch request.
REQ-010 hold_addr_i  in  ADDR_W  refetch address.
REQ-011 dm_halt_req_i  in  1  debug halt; stops issuing fetches.
REQ-012 dm_reset_req_i  in  1  debug reset; synchronous soft reset.
REQ-013 req_valid_o  out  1  fetch request valid.
REQ-014 req_addr_o  out  ADDR_W  fetch address, equals current PC.
REQ-015 req_ready_i  in  1  memory accepts request.
REQ-016 rsp_valid_i  in  1  instruction return, in request order, always accepted.
REQ-017 rsp_data_i  in  32  returned instruction.
REQ-018 inst_valid_o  out  1  delivered instruction valid (one-cycle pulse per instruction).
REQ-019 inst_o  out  32  delivered instruction.
REQ-020 inst_addr_o  out  ADDR_W  address of delivered instruction.
REQ-021 err_o  out  1  sticky protocol error.

Function
REQ-022 State: PC register, in-order address-tag FIFO of MAX_OUT entries, outstanding counter (0..MAX_OUT), kill counter (0..MAX_OUT).
REQ-023 Issue fire = req_valid_o & req_ready_i; on fire, PC <= PC+STEP modulo 2^ADDR_W, PC pushed to tag FIFO, outstanding +1.
REQ-024 req_valid_o = 1 only when not redirecting this cycle, dm_halt_req_i=0, dm_reset_req_i=0, outstanding < MAX_OUT.
REQ-025 req_valid_o once high SHALL stay high with req_addr_o stable until fire, unless a redirect, halt or debug reset occurs.
REQ-026 Response: rsp_valid_i pops tag FIFO head, outstanding -1; if kill counter > 0, response discarded and kill counter -1; else next cycle inst_valid_o=1, inst_o=rsp_data_i, inst_addr_o=popped tag (latency 1).
REQ-027 Redirect priority: dm_reset_req_i > jump_flag_i > hold_flag_i > dm_halt_req_i > sequential.
REQ-028 Jump: PC <= jump_addr_i; no issue that cycle; kill counter <= in-flight count remaining after this cycle's pop.
REQ-029 Hold: PC <= hold_addr_i; no issue; kill counter set as REQ-028; repeats each cycle hold_flag_i is high.
REQ-030 Halt: PC held, no issue; in-flight responses still drained and delivered; issue resumes at held PC the cycle after dm_halt_req_i falls.
REQ-031 Debug reset: PC <= RESET_PC, all in-flight marked killed, inst_valid_o <= 0, err_o unchanged.
REQ-032 Simultaneous fire and response: outstanding unchanged; FIFO push and pop both performed.
REQ-033 rsp_valid_i with outstanding=0: ignored (no pop, no delivery), err_o <= 1.
REQ-034 Redirect while outstanding=MAX_OUT: kill counter = MAX_OUT minus same-cycle pop; no overflow.
REQ-035 Misaligned jump/hold target (not multiple of STEP) accepted unmodified.

Reset
REQ-036 rst low asynchronously forces PC=RESET_PC, outstanding=0, kill=0, FIFO empty, inst_valid_o=0, inst_o=0, inst_addr_o=0, err_o=0, req_valid_o=0.
REQ-037 First request presented in the first cycle after rst is sampled high, with req_addr_o=RESET_PC.
REQ-038 err_o cleared only by rst.

Verification
REQ-039 Sequential: RESET_PC=0, req_ready_i=1, 1-cycle memory -> req_addr_o 0,4,8,...; inst_addr_o 0,4,8 one cycle after each rsp.
REQ-040 Backpressure: MAX_OUT=2, rsp withheld -> after 2 fires req_valid_o=0; one rsp -> req_valid_o=1 next cycle at addr 8.
REQ-041 Jump flush: 2 in flight (0,4), jump to 0x100 -> both responses discarded, next req_addr_o=0x100, first inst_addr_o=0x100.
REQ-042 Halt: dm_halt_req_i high with PC=0x20 -> req_valid_o=0, pending rsps delivered; release -> req_addr_o=0x20.
REQ-043 Priority: jump_flag_i, hold_flag_i, dm_halt_req_i high together -> PC=jump_addr_i; add dm_reset_req_i -> PC=RESET_PC.
REQ-044 Error/wrap: rsp_valid_i with nothing in flight -> err_o=1 sticky; PC=0xFFFFFFFC fire -> next req_addr_o=0.

Source files
------------

// File: rtl/pc_fetch_gen.sv
// Instruction fetch address generator: issues sequential fetches, tracks in-flight
// requests in an address-tag FIFO, and flushes responses after redirects.
module pc_fetch_gen #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                STEP     = 4,
  parameter int                MAX_OUT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              hold_flag_i,
  input  logic [ADDR_W-1:0] hold_addr_i,
  input  logic              dm_halt_req_i,
  input  logic              dm_reset_req_i,
  output logic              req_valid_o,
  output logic [ADDR_W-1:0] req_addr_o,
  input  logic              req_ready_i,
  input  logic              rsp_valid_i,
  input  logic [31:0]       rsp_data_i,
  output logic              inst_valid_o,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              err_o
);

  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  logic [ADDR_W-1:0] pc, pc_next;
  logic [ADDR_W-1:0] tag_fifo [MAX_OUT];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  outstanding, outstanding_next;
  logic [CNT_W-1:0]  kill_cnt, kill_next, in_flight_after_pop;
  logic              started, redirect, fire, pop, drop, deliver;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (MAX_OUT == 1) return '0;
    else return p + PTR_W'(1);
  endfunction

  // Redirects and halt suppress issue; killed responses are the oldest in flight.
  always_comb begin
    redirect            = dm_reset_req_i | jump_flag_i | hold_flag_i;
    req_valid_o         = started & ~redirect & ~dm_halt_req_i & (outstanding < MAX_CNT);
    req_addr_o          = pc;
    fire                = req_valid_o & req_ready_i;
    pop                 = rsp_valid_i & (outstanding != '0);
    drop                = pop & (kill_cnt != '0);
    deliver             = pop & ~drop & ~dm_reset_req_i;
    in_flight_after_pop = outstanding - CNT_W'(pop);
    outstanding_next    = in_flight_after_pop + CNT_W'(fire);
    kill_next           = kill_cnt - CNT_W'(drop);
    if (redirect) kill_next = in_flight_after_pop;
    pc_next = pc;
    if (dm_reset_req_i)   pc_next = RESET_PC;
    else if (jump_flag_i) pc_next = jump_addr_i;
    else if (hold_flag_i) pc_next = hold_addr_i;
    else if (fire)        pc_next = pc + ADDR_W'(STEP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc           <= RESET_PC;
      started      <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      outstanding  <= '0;
      kill_cnt     <= '0;
      inst_valid_o <= 1'b0;
      inst_o       <= '0;
      inst_addr_o  <= '0;
      err_o        <= 1'b0;
    end else begin
      pc           <= pc_next;
      started      <= 1'b1;
      outstanding  <= outstanding_next;
      kill_cnt     <= kill_next;
      inst_valid_o <= deliver;
      if (fire) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (deliver) begin
        inst_o      <= rsp_data_i;
        inst_addr_o <= tag_fifo[rd_ptr];
      end
      if (rsp_valid_i && outstanding == '0) err_o <= 1'b1;
    end
  end

  // Tag storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (fire) tag_fifo[wr_ptr] <= pc;
  end

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Directed bench for pc_fetch_gen: a queue-based reference model checks every
// cycle, and literal expectations pin the key scenarios.
module tb_pc_fetch_gen;

  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_i, hold_flag_i, dm_halt_req_i, dm_reset_req_i;
  logic [31:0] jump_addr_i, hold_addr_i;
  logic        req_valid_o, req_ready_i, rsp_valid_i, inst_valid_o, err_o;
  logic [31:0] req_addr_o, rsp_data_i, inst_o, inst_addr_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    bit          killed;
  } entry_t;

  entry_t      q[$];
  logic [31:0] m_pc;
  bit          m_started, m_inst_valid, m_err;
  logic [31:0] m_inst, m_inst_addr;

  pc_fetch_gen #(.ADDR_W(32), .RESET_PC(32'h0), .STEP(4), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .hold_flag_i(hold_flag_i), .hold_addr_i(hold_addr_i),
    .dm_halt_req_i(dm_halt_req_i), .dm_reset_req_i(dm_reset_req_i),
    .req_valid_o(req_valid_o), .req_addr_o(req_addr_o), .req_ready_i(req_ready_i),
    .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  function automatic void check_output(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic apply_stimulus(input logic jf, input logic [31:0] ja, input logic hf,
                                input logic [31:0] ha, input logic halt, input logic dbg,
                                input logic rdy, input logic rv, input logic [31:0] rd);
    @(negedge clk);
    jump_flag_i    = jf;
    jump_addr_i    = ja;
    hold_flag_i    = hf;
    hold_addr_i    = ha;
    dm_halt_req_i  = halt;
    dm_reset_req_i = dbg;
    req_ready_i    = rdy;
    rsp_valid_i    = rv;
    rsp_data_i     = rd;
  endtask

  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rd);
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, rdy, rv, rd);
  endtask

  // Reference model: sampled just before each rising edge, after inputs settle.
  always begin
    bit     exp_rv, fire;
    entry_t e;
    @(negedge clk);
    #3;
    if (!rst) begin
      q.delete();
      m_pc = 32'h0; m_started = 0; m_inst_valid = 0; m_err = 0;
      m_inst = 32'h0; m_inst_addr = 32'h0;
      check_output("m_reset_req_valid", {31'b0, req_valid_o}, 32'h0);
      check_output("m_reset_inst_valid", {31'b0, inst_valid_o}, 32'h0);
      check_output("m_reset_inst", inst_o, 32'h0);
      check_output("m_reset_inst_addr", inst_addr_o, 32'h0);
      check_output("m_reset_err", {31'b0, err_o}, 32'h0);
    end else begin
      exp_rv = m_started && !dm_reset_req_i && !jump_flag_i && !hold_flag_i &&
               !dm_halt_req_i && (q.size() < MAX_OUT);
      check_output("m_req_valid", {31'b0, req_valid_o}, {31'b0, exp_rv});
      if (exp_rv) check_output("m_req_addr", req_addr_o, m_pc);
      check_output("m_inst_valid", {31'b0, inst_valid_o}, {31'b0, m_inst_valid});
      if (m_inst_valid) begin
        check_output("m_inst", inst_o, m_inst);
        check_output("m_inst_addr", inst_addr_o, m_inst_addr);
      end
      check_output("m_err", {31'b0, err_o}, {31'b0, m_err});

      fire = exp_rv && req_ready_i;
      m_inst_valid = 0;
      if (rsp_valid_i) begin
        if (q.size() == 0) m_err = 1;
        else begin
          e = q.pop_front();
          if (!e.killed && !dm_reset_req_i) begin
            m_inst_valid = 1;
            m_inst       = rsp_data_i;
            m_inst_addr  = e.addr;
          end
        end
      end
      if (dm_reset_req_i || jump_flag_i || hold_flag_i)
        foreach (q[i]) q[i].killed = 1;
      if (fire) q.push_back('{m_pc, 1'b0});
      if (dm_reset_req_i)   m_pc = 32'h0;
      else if (jump_flag_i) m_pc = jump_addr_i;
      else if (hold_flag_i) m_pc = hold_addr_i;
      else if (fire)        m_pc = m_pc + 32'd4;
      m_started = 1;
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    jump_flag_i = 0; jump_addr_i = 0; hold_flag_i = 0; hold_addr_i = 0;
    dm_halt_req_i = 0; dm_reset_req_i = 0; req_ready_i = 0; rsp_valid_i = 0; rsp_data_i = 0;

    // Reset state
    cyc(1'b1, 1'b0, 32'h0); #3;
    check_output("rst_req_valid", {31'b0, req_valid_o}, 32'h0);
    check_output("rst_err", {31'b0, err_o}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    req_ready_i = 1'b0;

    // Sequential fetch with a one-cycle memory
    cyc(1'b1, 1'b0, 32'h0); #3;
    check_output("first_req_addr", req_addr_o, 32'h0);
    check_output("first_req_valid", {31'b0, req_valid_o}, 32'h1);
    cyc(1'b1, 1'b1, 32'hA000_0000); #3;
    check_output("seq_req_addr_4", req_addr_o, 32'h4);
    cyc(1'b1, 1'b1, 32'hA000_0004); #3;
    check_output("seq_inst_addr_0", inst_addr_o, 32'h0);
    check_output("seq_inst_0", inst_o, 32'hA000_0000);
    check_output("seq_req_addr_8", req_addr_o, 32'h8);
    cyc(1'b1, 1'b1, 32'hA000_0008); #3;
    check_output("seq_inst_addr_4", inst_addr_o, 32'h4);
    cyc(1'b0, 1'b1, 32'hA000_000C); #3;
    check_output("seq_inst_addr_8", inst_addr_o, 32'h8);
    cyc(1'b0, 1'b0, 32'h0); #3;
    check_output("seq_inst_addr_c", inst_addr_o, 32'hC);

    // Debug reset back to 0, then backpressure at MAX_OUT
    apply_stimulus(0, 0, 0, 0, 0, 1, 1, 0, 0); #3;
    check_output("dbg_req_valid", {31'b0, req_valid_o}, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0); #3;
    check_output("full_req_valid", {31'b0, req_valid_o}, 32'h0);
    cyc(1'b1, 1'b1, 32'hB000_0000);
    cyc(1'b1, 1'b0, 32'h0); #3;
    check_output("bp_req_valid", {31'b0, req_valid_o}, 32'h1);
    check_output("bp_req_addr", req_addr_o, 32'h8);

    // Jump flush with 4 and 8 in flight
    apply_stimulus(1, 32'h100, 0, 0, 0, 0, 1, 0, 0); #3;
    check_output("jump_req_valid", {31'b0, req_valid_o}, 32'h0);
    cyc(1'b0, 1'b1, 32'hDEAD_0004); #3;
    check_output("jump_req_addr", req_addr_o, 32'h100);
    cyc(1'b1, 1'b1, 32'hDEAD_0008); #3;
    check_output("flush_inst_valid_a", {31'b0, inst_valid_o}, 32'h0);
    cyc(1'b0, 1'b1, 32'hC000_0100); #3;
    check_output("flush_inst_valid_b", {31'b0, inst_valid_o}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0); #3;
    check_output("jump_inst_addr", inst_addr_o, 32'h100);
    check_output("jump_inst", inst_o, 32'hC000_0100);

    // Halt with PC at 0x20 and two fetches pending
    apply_stimulus(1, 32'h18, 0, 0, 0, 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    apply_stimulus(0, 0, 0, 0, 1, 0, 1, 0, 0); #3;
    check_output("halt_req_valid", {31'b0, req_valid_o}, 32'h0);
    apply_stimulus(0, 0, 0, 0, 1, 0, 1, 1, 32'hD000_0018);
    apply_stimulus(0, 0, 0, 0, 1, 0, 1, 1, 32'hD000_001C); #3;
    check_output("halt_inst_addr_18", inst_addr_o, 32'h18);
    cyc(1'b0, 1'b0, 32'h0); #3;
    check_output("halt_inst_addr_1c", inst_addr_o, 32'h1C);
    check_output("resume_req_addr", req_addr_o, 32'h20);

    // Priority among simultaneous redirect sources
    apply_stimulus(1, 32'h200, 1, 32'h300, 1, 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 32'h0); #3;
    check_output("prio_jump_addr", req_addr_o, 32'h200);
    apply_stimulus(1, 32'h200, 1, 32'h300, 1, 1, 0, 0, 0);
    cyc(1'b0, 1'b0, 32'h0); #3;
    check_output("prio_dbg_addr", req_addr_o, 32'h0);

    // Repeated hold, last target misaligned
    apply_stimulus(0, 0, 1, 32'h40, 0, 0, 1, 0, 0);
    apply_stimulus(0, 0, 1, 32'h46, 0, 0, 1, 0, 0);
    cyc(1'b0, 1'b0, 32'h0); #3;
    check_output("hold_misaligned_addr", req_addr_o, 32'h46);

    // Spurious response sets sticky error; PC wraps
    cyc(1'b0, 1'b1, 32'h1234_5678);
    cyc(1'b0, 1'b0, 32'h0); #3;
    check_output("err_set", {31'b0, err_o}, 32'h1);
    apply_stimulus(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0); #3;
    check_output("wrap_req_addr", req_addr_o, 32'h0);
    check_output("err_sticky", {31'b0, err_o}, 32'h1);
    cyc(1'b0, 1'b1, 32'hE000_FFFC);
    cyc(1'b0, 1'b0, 32'h0); #3;
    check_output("wrap_inst_addr", inst_addr_o, 32'hFFFF_FFFC);

    // Debug reset kills an in-flight fetch but keeps err_o
    cyc(1'b1, 1'b0, 32'h0);
    apply_stimulus(0, 0, 0, 0, 0, 1, 1, 0, 0);
    cyc(1'b0, 1'b1, 32'hBAD0_0000);
    cyc(1'b0, 1'b0, 32'h0); #3;
    check_output("dbg_kill_inst_valid", {31'b0, inst_valid_o}, 32'h0);
    check_output("dbg_keeps_err", {31'b0, err_o}, 32'h1);
    check_output("dbg_req_addr", req_addr_o, 32'h0);

    // Asynchronous reset mid-run
    @(negedge clk);
    rst = 1'b0;
    #3;
    check_output("async_rst_err", {31'b0, err_o}, 32'h0);
    check_output("async_rst_req_valid", {31'b0, req_valid_o}, 32'h0);
    @(negedge clk);
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
